// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: single-outstanding miss handler for the 4-way, 128-set,
// 64-byte-line write-through data cache. Fetches a line as 16 beats, picks a
// victim (first invalid way, else per-set round-robin), writes the line into
// the arrays, then replays the original request.
//
// state  | meaning
// IDLE   | ready for a new miss
// REQ    | line read request presented to memory
// FILL   | collecting beats into the line buffer
// WRITE  | one-cycle fill strobe to the cache arrays
// REPLAY | re-issuing the captured request to the cache pipeline
module dcache_miss_ctrl #(
    parameter int WAYS  = 4,
    parameter int SETS  = 128,
    parameter int BEATS = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [31:0]           miss_addr,
    input  logic [31:0]           miss_pc,
    input  logic                  miss_is_store,
    input  logic                  miss_store_size,
    input  logic [3:0]            set_valid,
    input  logic                  flush,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [31:0]           mem_req_addr,
    input  logic                  mem_rdata_valid,
    input  logic [31:0]           mem_rdata,
    output logic                  fill_valid,
    output logic [1:0]            fill_way,
    output logic [6:0]            fill_index,
    output logic [18:0]           fill_tag,
    output logic [BEATS*32-1:0]   fill_data,
    output logic                  replay_valid,
    input  logic                  replay_ready,
    output logic [31:0]           replay_pc,
    output logic [31:0]           replay_addr,
    output logic                  replay_is_store,
    output logic                  replay_store_size,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, REPLAY} state_t;

    state_t               state;
    logic [3:0]           beat;
    logic                 kill;
    logic [1:0]           rr [SETS];
    logic [BEATS*32-1:0]  line_buf;
    logic [31:0]          cap_addr;
    logic [31:0]          cap_pc;
    logic                 cap_is_store;
    logic                 cap_store_size;
    logic [1:0]           victim;
    logic [1:0]           victim_sel;

    // Victim choice: lowest invalid way wins, otherwise the set's round-robin pointer
    always_comb begin
        victim_sel = rr[miss_addr[12:6]];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) victim_sel = w[1:0];
        end
    end

    // Main controller: state, beat counter, kill flag, line buffer and captured request
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            beat           <= 4'd0;
            kill           <= 1'b0;
            line_buf       <= '0;
            cap_addr       <= 32'd0;
            cap_pc         <= 32'd0;
            cap_is_store   <= 1'b0;
            cap_store_size <= 1'b0;
            victim         <= 2'd0;
            for (int s = 0; s < SETS; s++) rr[s] <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        cap_addr       <= miss_addr;
                        cap_pc         <= miss_pc;
                        cap_is_store   <= miss_is_store;
                        cap_store_size <= miss_store_size;
                        victim         <= victim_sel;
                        kill           <= 1'b0;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    // A flush coinciding with the handshake lets the fetch proceed
                    // but the replay is no longer wanted.
                    if (mem_req_ready) begin
                        beat  <= 4'd0;
                        kill  <= flush;
                        state <= FILL;
                    end else if (flush) begin
                        state <= IDLE;
                    end
                end
                FILL: begin
                    if (flush) kill <= 1'b1;
                    if (mem_rdata_valid) begin
                        line_buf[beat*32 +: 32] <= mem_rdata;
                        beat <= beat + 4'd1;
                        if (beat == 4'(BEATS - 1)) state <= WRITE;
                    end
                end
                WRITE: begin
                    rr[cap_addr[12:6]] <= victim + 2'd1;
                    kill  <= 1'b0;
                    state <= (kill || flush) ? IDLE : REPLAY;
                end
                REPLAY: begin
                    if (flush || replay_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign miss_ready        = (state == IDLE);
    assign busy              = (state != IDLE);
    assign mem_req_valid     = (state == REQ);
    assign fill_valid        = (state == WRITE);
    assign replay_valid      = (state == REPLAY);
    assign mem_req_addr      = {cap_addr[31:6], 6'b0};
    assign fill_way          = victim;
    assign fill_index        = cap_addr[12:6];
    assign fill_tag          = cap_addr[31:13];
    assign fill_data         = line_buf;
    assign replay_pc         = cap_pc;
    assign replay_addr       = cap_addr;
    assign replay_is_store   = cap_is_store;
    assign replay_store_size = cap_store_size;

endmodule

// File: doc/dcache_miss_ctrl.md
# dcache_miss_ctrl

Miss-handling controller for the 4-way, 128-set, 64-byte-line data cache. It accepts one miss at a time from the cache lookup stage and fetches the line from memory as 16 32-bit beats. It picks a victim way, writes the line into the cache arrays, then replays the original request into the cache pipeline. The cache is write-through, so the controller never writes back victims.

## Interface
- WAYS, 4, cache associativity (way index 2 bits)
- SETS, 128, sets per way (index = addr[12:6])
- BEATS, 16, 32-bit memory beats per 64-byte line
- clk  in  1  system clock, all state updates on rising edge
- rstn  in  1  asynchronous, active-low reset
- miss_valid  in  1  cache reports a miss
- miss_ready  out  1  controller can accept a miss (high only in IDLE)
- miss_addr  in  32  full byte address of the missing access
- miss_pc  in  32  PC of the missing instruction
- miss_is_store  in  1  missing access was a store
- miss_store_size  in  1  0: word, 1: byte (carried to replay)
- set_valid  in  4  valid bits of ways 0..3 at miss_addr[12:6], same cycle as miss_valid
- flush  in  1  pipeline flush; kills the pending replay
- mem_req_valid  out  1  line read request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  line-aligned address {miss_addr[31:6], 6'b0}
- mem_rdata_valid  in  1  one beat returned
- mem_rdata  in  32  beat data
- fill_valid  out  1  one-cycle strobe: write line into cache
- fill_way  out  2  victim way
- fill_index  out  7  set index
- fill_tag  out  19  miss_addr[31:13]
- fill_data  out  512  assembled line, beat k at bits [32k+31:32k]
- replay_valid  out  1  re-issue request to cache
- replay_ready  in  1  cache pipeline accepts replay
- replay_pc, replay_addr  out  32 each  captured PC and address
- replay_is_store, replay_store_size  out  1 each  captured control bits
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, FILL, WRITE, REPLAY.
- IDLE: miss_ready=1. When miss_valid=1, capture addr, pc, is_store, store_size, and victim, then go to REQ.
- Victim selection: lowest-numbered way with set_valid bit 0. If all four ways are valid, use the per-set round-robin pointer rr[index] (128×2-bit).
- REQ: mem_req_valid=1. The request stays stable until mem_req_ready=1, then go to FILL with beat counter=0.
- FILL: each mem_rdata_valid writes mem_rdata into line slot [beat] and increments beat (4-bit). Beat 15 goes to WRITE. mem_rdata_valid is ignored in every other state.
- WRITE: fill_valid=1 for exactly one cycle. Set rr[index] ← fill_way+1 (mod 4, wraps 3→0). If the kill flag is set, go to IDLE; otherwise go to REPLAY.
- REPLAY: replay_valid=1, with fields held stable until replay_ready=1, then go to IDLE.
- flush behaviour by state:
  - IDLE: no effect.
  - REQ, before the handshake: go to IDLE immediately; no memory request is issued that cycle.
  - REQ with mem_req_ready in the same cycle: the handshake completes.
  - REQ after the handshake, or FILL: set the kill flag. The fill still completes and is written, because the data is correct; the replay is suppressed.
  - WRITE: sets the kill flag, so REPLAY is skipped.
  - REPLAY: drop replay_valid and go to IDLE.
- miss_valid while not in IDLE is not accepted (miss_ready=0); the cache holds the miss.

## Timing
- Reset (rstn=0, async) state:
  - State = IDLE, beat counter = 0, kill flag = 0.
  - All rr = 0, line buffer = 0, captured fields = 0.
  - Outputs: mem_req_valid, fill_valid, replay_valid and busy = 0; miss_ready = 1.
- Reset mid-operation abandons the transaction immediately. Memory beats arriving after reset are ignored.
- Accepting a miss at edge N drives mem_req_valid from cycle N+1 (registered).
- Handshake at edge M: the first beat can be accepted at edge M+1.
- The 16th beat at edge B makes fill_valid high in cycle B+1, and replay_valid is high from cycle B+2.
- Minimum miss→replay: 1 (REQ) + 16 (beats) + 1 (WRITE) + 1 = 19 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from mem_* inputs to outputs.
- Back-to-back: a new miss can be accepted in the IDLE cycle right after the replay handshake.

## Test plan
- Cold miss: set_valid=0000, miss_addr=0x0000_1A44, memory returns beats 0x100..0x10F with no stalls.
  - mem_req_addr=0x0000_1A40.
  - fill_way=0, fill_index=0x69, fill_tag=0x0000.
  - fill_data[31:0]=0x100 and fill_data[511:480]=0x10F.
  - replay_addr=0x0000_1A44 exactly 19 cycles after acceptance.
- Full set: four misses to index 5 with set_valid=1111 and rr[5]=0 give victims 0,1,2,3, then a fifth miss gives victim 0 again (wrap).
- Partial valid: set_valid=1011 → fill_way=2, and rr[index] becomes 3.
- Stalls: hold mem_req_ready=0 for 5 cycles and insert random gaps in mem_rdata_valid; the line still assembles in order and fill_valid pulses once. Hold replay_ready=0 for 3 cycles; replay fields stay stable.
- Flush in FILL at beat 7: fill_valid still pulses, replay_valid never rises, and busy falls the cycle after WRITE. Flush in REQ before mem_req_ready: no fill, immediate IDLE.
- Assert rstn=0 at beat 9, release it, then issue a new miss: the controller restarts from beat 0, and stale beats from before reset do not appear in fill_data.
